// File: rtl/fpm_pkg.sv
// Shared encodings and constants for the binary32 multiplier back end.
// Holds the operand class encoding, exponent limits, the canonical NaN and flag positions.
package fpm_pkg;

  typedef enum logic [1:0] {
    CLS_NORM = 2'd0,
    CLS_ZERO = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } fpm_cls_e;

  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // Bit positions inside out_flags = {overflow, underflow, inexact}
  localparam int FLAG_OVF = 2;
  localparam int FLAG_UNF = 1;
  localparam int FLAG_INX = 0;

  // Contents of the normalise register stage
  typedef struct packed {
    logic               sign;
    fpm_cls_e           cls;
    logic signed [10:0] exp;
    logic [23:0]        sig;
    logic               guard;
    logic               sticky;
  } stage_a_t;

  function automatic logic [31:0] pack_inf(input logic sign);
    return {sign, 8'hFF, 23'h0};
  endfunction

  function automatic logic [31:0] pack_zero(input logic sign);
    return {sign, 31'h0};
  endfunction

endpackage

// File: rtl/fpm_rne_round.sv
// Combinational round-to-nearest-even on a normalised 24-bit significand.
// A carry out of the significand renormalises by one place and bumps the exponent.
module fpm_rne_round
  import fpm_pkg::*;
(
  input  logic [23:0]        sig,
  input  logic               guard,
  input  logic               sticky,
  input  logic signed [10:0] exp,
  output logic [23:0]        sig_rnd,
  output logic signed [10:0] exp_rnd,
  output logic               inexact
);

  logic        round_up;
  logic [24:0] sum;

  always_comb begin
    round_up = guard & (sticky | sig[0]);
    sum      = {1'b0, sig} + {24'd0, round_up};
    if (sum[24]) begin
      // Only an all-ones significand carries out, so the dropped bit is always zero
      sig_rnd = sum[24:1];
      exp_rnd = exp + 11'sd1;
    end else begin
      sig_rnd = sum[23:0];
      exp_rnd = exp;
    end
    inexact = guard | sticky;
  end

endmodule

// File: rtl/fpm_round_norm.sv
// Normalise-and-round output stage of the binary32 multiplier: two registered
// stages behind a fully backpressured valid/ready handshake.
module fpm_round_norm
  import fpm_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [9:0]  in_exp,
  input  logic [47:0] in_man,
  input  logic [1:0]  in_cls,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [2:0]  out_flags
);

  // Handshake: a stage advances when it is empty or the stage after it advances.
  // Data moves on valid & ready; a stage that advances with nothing behind it goes empty.
  logic     adv_a;
  logic     adv_b;
  logic     valid_a;
  stage_a_t stage_a;
  stage_a_t norm_a;

  assign adv_b    = !out_valid | out_ready;
  assign adv_a    = !valid_a | adv_b;
  assign in_ready = adv_a;

  always_comb begin
    norm_a.sign = in_sign;
    norm_a.cls  = fpm_cls_e'(in_cls);
    if (in_man[47]) begin
      norm_a.sig    = in_man[47:24];
      norm_a.guard  = in_man[23];
      norm_a.sticky = |in_man[22:0];
      norm_a.exp    = $signed({in_exp[9], in_exp}) + 11'sd1;
    end else begin
      norm_a.sig    = in_man[46:23];
      norm_a.guard  = in_man[22];
      norm_a.sticky = |in_man[21:0];
      norm_a.exp    = $signed({in_exp[9], in_exp});
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_a <= 1'b0;
      stage_a <= '0;
    end else if (adv_a) begin
      valid_a <= in_valid;
      if (in_valid) begin
        stage_a <= norm_a;
      end
    end
  end

  logic [23:0]        sig_rnd;
  logic signed [10:0] exp_rnd;
  logic               inexact;

  fpm_rne_round u_round (
    .sig     (stage_a.sig),
    .guard   (stage_a.guard),
    .sticky  (stage_a.sticky),
    .exp     (stage_a.exp),
    .sig_rnd (sig_rnd),
    .exp_rnd (exp_rnd),
    .inexact (inexact)
  );

  logic [31:0] res_data;
  logic [2:0]  res_flags;

  always_comb begin
    res_data  = '0;
    res_flags = '0;
    case (stage_a.cls)
      CLS_ZERO: res_data = pack_zero(stage_a.sign);
      CLS_INF:  res_data = pack_inf(stage_a.sign);
      CLS_NAN:  res_data = QNAN;
      default: begin
        if (exp_rnd >= $signed(11'(EXP_MAX))) begin
          res_data            = pack_inf(stage_a.sign);
          res_flags[FLAG_OVF] = 1'b1;
          res_flags[FLAG_INX] = 1'b1;
        end else if (exp_rnd <= 11'sd0 || !sig_rnd[23]) begin
          // No subnormal output; an unnormalised product is flushed the same way
          res_data            = pack_zero(stage_a.sign);
          res_flags[FLAG_UNF] = 1'b1;
          res_flags[FLAG_INX] = 1'b1;
        end else begin
          res_data            = {stage_a.sign, exp_rnd[7:0], sig_rnd[22:0]};
          res_flags[FLAG_INX] = inexact;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_flags <= '0;
    end else if (adv_b) begin
      out_valid <= valid_a;
      if (valid_a) begin
        out_data  <= res_data;
        out_flags <= res_flags;
      end
    end
  end

endmodule

// File: tb/tb_fpm_round_norm.sv
// Bench for fpm_round_norm: directed corner vectors, a backpressure burst,
// reset with results in flight, then randomized traffic against an arithmetic model.
module tb_fpm_round_norm;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [9:0]  in_exp = '0;
  logic [47:0] in_man = '0;
  logic [1:0]  in_cls = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [2:0]  out_flags;

  int n_checks = 0;
  int n_errors = 0;

  logic [34:0] exp_q[$];
  int          occ = 0;
  int          ready_mode = 0;
  int          pat_idx = 0;
  logic        pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic        prev_stall = 1'b0;
  logic [34:0] prev_out = '0;

  fpm_round_norm dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_man    (in_man),
    .in_cls    (in_cls),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_flags (out_flags)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // ---------------- reference model ----------------
  // Rounds by comparing the discarded remainder against one half ulp.
  function automatic logic [34:0] model(input logic s, input logic [9:0] e10,
                                        input logic [47:0] m, input logic [1:0] c);
    longint unsigned mm, sig, rem, half;
    int sh, e;
    logic inx;
    if (c == 2'd1) return {3'b000, s, 31'd0};
    if (c == 2'd2) return {3'b000, s, 8'hFF, 23'd0};
    if (c == 2'd3) return {3'b000, 32'h7FC0_0000};
    mm   = 64'(m);
    sh   = m[47] ? 24 : 23;
    e    = $signed(e10);
    e    = e + (m[47] ? 1 : 0);
    sig  = mm >> sh;
    rem  = mm & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && sig[0])) sig = sig + 64'd1;
    if (sig == (64'd1 << 24)) begin
      sig = sig >> 1;
      e   = e + 1;
    end
    inx = (rem != 0);
    if (e >= 255) return {3'b101, s, 8'hFF, 23'd0};
    if (e <= 0)   return {3'b011, s, 31'd0};
    return {2'b00, inx, s, e[7:0], sig[22:0]};
  endfunction

  // ---------------- out_ready driver ----------------
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1: out_ready = ($urandom_range(0, 9) < 7);
      2: begin
        out_ready = pat[pat_idx % 6];
        pat_idx++;
      end
      3: out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
  end

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    logic acc, emit;
    logic [34:0] want;
    if (!rst) begin
      occ        = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_hold", 64'({out_flags, out_data}), 64'(prev_out));
      end
      check("in_ready", 64'(in_ready), 64'((occ < 2) || out_ready));
      acc  = in_valid & in_ready;
      emit = out_valid & out_ready;
      if (emit) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 64'(out_valid), 64'd0);
        end else begin
          want = exp_q.pop_front();
          check("out_data", 64'(out_data), 64'(want[31:0]));
          check("out_flags", 64'(out_flags), 64'(want[34:32]));
        end
      end
      if (acc) exp_q.push_back(model(in_sign, in_exp, in_man, in_cls));
      occ        = occ + int'(acc) - int'(emit);
      prev_stall = out_valid & !out_ready;
      prev_out   = {out_flags, out_data};
    end
  end

  // ---------------- driver tasks ----------------
  // Call shortly after a rising edge; returns just after the edge that took the input.
  task automatic send(input logic s, input logic [9:0] e, input logic [47:0] m, input logic [1:0] c);
    logic acc;
    int   n;
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = e;
    in_man   = m;
    in_cls   = c;
    n        = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) check("send_timeout", 64'(acc), 64'd1);
    in_valid = 1'b0;
  endtask

  // Inputs presented after edge n show up on the output after edge n+2.
  task automatic run_vec(input string tag, input logic s, input logic [9:0] e,
                         input logic [47:0] m, input logic [1:0] c,
                         input logic [31:0] wd, input logic [2:0] wf);
    send(s, e, m, c);
    @(negedge clk);
    check({tag, "_early"}, 64'(out_valid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_data"}, 64'(out_data), 64'(wd));
    check({tag, "_flags"}, 64'(out_flags), 64'(wf));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    ready_mode = 0;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [23:0] a, b;
    logic [9:0]  e;
    logic [1:0]  c;
    int          r;
    int          edge_e[6] = '{-2, -1, 0, 1, 253, 254};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_flags", 64'(out_flags), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    run_vec("mul2x4",   1'b0, 10'd130, 48'h4000_0000_0000, 2'd0, 32'h4100_0000, 3'b000);
    run_vec("tie_even", 1'b0, 10'd127, 48'h4000_0040_0000, 2'd0, 32'h3F80_0000, 3'b001);
    run_vec("tie_odd",  1'b0, 10'd127, 48'h4000_00C0_0000, 2'd0, 32'h3F80_0002, 3'b001);
    run_vec("rnd_carry",1'b0, 10'd127, 48'h7FFF_FFC0_0000, 2'd0, 32'h4000_0000, 3'b001);
    run_vec("overflow", 1'b0, 10'd254, 48'h8000_0000_0000, 2'd0, 32'h7F80_0000, 3'b101);
    run_vec("max_norm", 1'b0, 10'd253, 48'h8000_0000_0000, 2'd0, 32'h7F00_0000, 3'b000);
    run_vec("underflow",1'b1, 10'd0,   48'h4000_0000_0000, 2'd0, 32'h8000_0000, 3'b011);
    run_vec("min_norm", 1'b1, 10'd1,   48'h4000_0000_0000, 2'd0, 32'h8080_0000, 3'b000);
    run_vec("nan",      1'b1, 10'd5,   48'h0000_0000_0123, 2'd3, 32'h7FC0_0000, 3'b000);
    run_vec("inf",      1'b1, 10'd5,   48'h0,              2'd2, 32'hFF80_0000, 3'b000);
    run_vec("zero",     1'b1, 10'd5,   48'h0,              2'd1, 32'h8000_0000, 3'b000);

    // Backpressure burst with a fixed out_ready pattern
    pat_idx    = 0;
    ready_mode = 2;
    for (int i = 0; i < 6; i++) begin
      a = {1'b1, 23'($urandom)};
      b = {1'b1, 23'($urandom)};
      send(1'(i), 10'(100 + i), {24'd0, a} * {24'd0, b}, 2'd0);
    end
    drain();

    // Reset with two results in flight
    ready_mode = 3;
    @(posedge clk);
    #2;
    send(1'b0, 10'd127, 48'h4000_0000_0000, 2'd0);
    send(1'b1, 10'd128, 48'h4000_0000_0000, 2'd0);
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("rst_flush_valid", 64'(out_valid), 64'd1 - 64'd1 + 64'(1'b0));
    check("rst_flush_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    rst        = 1'b1;
    ready_mode = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_stale", 64'(out_valid), 64'd0);
    end
    @(posedge clk);
    #1;

    // Randomized traffic with random backpressure
    ready_mode = 1;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 2);
      if (r != 0) begin
        repeat (r) @(posedge clk);
        #1;
      end
      r = $urandom_range(0, 9);
      c = (r < 7) ? 2'd0 : 2'(r - 6);
      if ($urandom_range(0, 3) == 0) e = 10'(edge_e[$urandom_range(0, 5)]);
      else e = 10'($urandom_range(0, 510) - 127);
      a = {1'b1, 23'($urandom)};
      b = {1'b1, 23'($urandom)};
      send(1'($urandom_range(0, 1)), e, {24'd0, a} * {24'd0, b}, c);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
